// File: rtl/hrm_gen_25b.sv
// Phase-rotation sample generator: emits sin/cos of alpha + n*delta by repeated
// angle addition, with a valid/ready handshake on the output samples.

module hrm_add_25b (
  input  logic [1:0][24:0] a_i,
  input  logic [1:0][24:0] b_i,
  output logic [1:0][24:0] y_o
);
  logic signed [24:0] as, ac, bs, bc;
  logic signed [49:0] p_sc, p_cs, p_cc, p_ss;
  logic signed [50:0] s_sum, c_sum;

  // Full-precision products and sums, rounded to nearest once at the end.
  function automatic logic [24:0] rnd_sat(input logic signed [50:0] v);
    logic signed [50:0] r;
    r = (v + 51'sd4194304) >>> 23;
    if (r > 51'sd16777215)
      return 25'h0FFFFFF;
    else if (r < -51'sd16777216)
      return 25'h1000000;
    else
      return r[24:0];
  endfunction

  always_comb begin
    as    = a_i[0];
    ac    = a_i[1];
    bs    = b_i[0];
    bc    = b_i[1];
    p_sc  = as * bc;
    p_cs  = ac * bs;
    p_cc  = ac * bc;
    p_ss  = as * bs;
    s_sum = {p_sc[49], p_sc} + {p_cs[49], p_cs};
    c_sum = {p_cc[49], p_cc} - {p_ss[49], p_ss};
    y_o[0] = rnd_sat(s_sum);
    y_o[1] = rnd_sat(c_sum);
  end
endmodule

module hrm_gen_25b #(
  parameter int CNT_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [1:0][24:0]      i_seed,
  input  logic [1:0][24:0]      i_delta,
  input  logic [CNT_W-1:0]      i_count,
  input  logic                  i_ready,
  output logic                  o_busy,
  output logic                  o_valid,
  output logic [1:0][24:0]      o_theta,
  output logic [CNT_W-1:0]      o_idx,
  output logic                  o_last,
  output logic                  o_done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0][24:0]   theta_q, theta_d;
  logic [1:0][24:0]   delta_q, delta_d;
  logic [1:0][24:0]   theta_next;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic               last;

  hrm_add_25b u_add (
    .a_i (theta_q),
    .b_i (delta_q),
    .y_o (theta_next)
  );

  // cnt_q is never zero in RUN, so cnt_q-1 cannot wrap.
  assign last = (state_q == RUN) && (idx_q == cnt_q - {{(CNT_W-1){1'b0}}, 1'b1});

  always_comb begin
    state_d = state_q;
    theta_d = theta_q;
    delta_d = delta_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          if (i_count != '0) begin
            theta_d = i_seed;
            delta_d = i_delta;
            cnt_d   = i_count;
            idx_d   = '0;
            state_d = RUN;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (i_ready) begin
          if (last) begin
            state_d = DONE;
          end else begin
            theta_d = theta_next;
            idx_d   = idx_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      theta_q <= '0;
      delta_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      theta_q <= theta_d;
      delta_q <= delta_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  assign o_valid = (state_q == RUN);
  assign o_busy  = (state_q != IDLE);
  assign o_done  = (state_q == DONE);
  assign o_last  = last;
  assign o_idx   = idx_q;
  assign o_theta = theta_q;
endmodule

// File: tb/tb_hrm_gen_25b.sv
// Scoreboard bench for hrm_gen_25b: expected samples come from ideal trig of
// alpha + n*delta, compared exactly or within a per-sequence tolerance.

module tb_hrm_gen_25b;
  localparam int  CW = 9;
  localparam real PI = 3.14159265358979323846;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [1:0][24:0]  seed, delta;
  logic [CW-1:0]     count;
  logic              ready;
  logic              busy, valid, last, done;
  logic [1:0][24:0]  theta;
  logic [CW-1:0]     idx;

  typedef struct {
    longint s;
    longint c;
    int     idx;
    bit     last;
    longint tol;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  int   busy_cnt = 0;
  int   valid_cnt = 0;

  hrm_gen_25b #(.CNT_W(CW)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_seed  (seed),
    .i_delta (delta),
    .i_count (count),
    .i_ready (ready),
    .o_busy  (busy),
    .o_valid (valid),
    .o_theta (theta),
    .o_idx   (idx),
    .o_last  (last),
    .o_done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint fx(input real v);
    real t;
    t = v * 8388608.0;
    if (t >= 0.0) return longint'($rtoi(t + 0.5));
    else          return -longint'($rtoi(-t + 0.5));
  endfunction

  function automatic longint absdiff(input longint a, input longint b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Monitor: compare the head of the scoreboard on every valid cycle, pop on handshake.
  always @(negedge clk) begin
    longint ds, dc;
    if (done)  done_cnt++;
    if (busy)  busy_cnt++;
    if (valid) begin
      valid_cnt++;
      if (q.size() == 0) begin
        check("unexpected_sample", 1, 0);
      end else begin
        ds = absdiff(longint'($signed(theta[0])), q[0].s);
        dc = absdiff(longint'($signed(theta[1])), q[0].c);
        check($sformatf("sin_err@%0d", q[0].idx), (ds > q[0].tol) ? ds : 0, 0);
        check($sformatf("cos_err@%0d", q[0].idx), (dc > q[0].tol) ? dc : 0, 0);
        check("idx", longint'(idx), longint'(q[0].idx));
        check($sformatf("last@%0d", q[0].idx), longint'(last), longint'(q[0].last));
        if (ready) void'(q.pop_front());
      end
    end
  end

  task automatic push_exp(input real a_deg, input real d_deg, input int n, input longint tol);
    real a, d;
    exp_t e;
    a = a_deg * PI / 180.0;
    d = d_deg * PI / 180.0;
    for (int k = 0; k < n; k++) begin
      e.s    = fx($sin(a + k * d));
      e.c    = fx($cos(a + k * d));
      e.idx  = k;
      e.last = (k == n - 1);
      e.tol  = tol;
      q.push_back(e);
    end
  endtask

  task automatic drive_start(input real a_deg, input real d_deg, input int n);
    seed[0]  = 25'(fx($sin(a_deg * PI / 180.0)));
    seed[1]  = 25'(fx($cos(a_deg * PI / 180.0)));
    delta[0] = 25'(fx($sin(d_deg * PI / 180.0)));
    delta[1] = 25'(fx($cos(d_deg * PI / 180.0)));
    count    = CW'(n);
    start    = 1'b1;
    ready    = 1'b1;
  endtask

  // Called at posedge+1; returns at posedge+1 once o_done has been observed.
  task automatic run_seq(input string name, input real a_deg, input real d_deg, input int n,
                         input longint tol, input int stall_idx, input int stall_len,
                         input bit rnd, input bit poke);
    int d0, b0, v0, cycles, stalls, stall_left;
    push_exp(a_deg, d_deg, n, tol);
    d0 = done_cnt; b0 = busy_cnt; v0 = valid_cnt;
    cycles = 0; stalls = 0; stall_left = stall_len;
    drive_start(a_deg, d_deg, n);
    while (done_cnt == d0 && cycles < 4 * n + 50) begin
      @(posedge clk); #1;
      cycles++;
      start = 1'b0;
      if (poke && cycles == 2) begin
        start = 1'b1;
        seed  = {25'($urandom), 25'($urandom)};
        delta = {25'($urandom), 25'($urandom)};
        count = CW'($urandom_range(1, 20));
      end
      if (rnd)
        ready = ($urandom_range(3) != 0);
      else if (valid && int'(idx) == stall_idx && stall_left > 0) begin
        ready = 1'b0;
        stall_left--;
      end else
        ready = 1'b1;
      if (valid && !ready) stalls++;
    end
    start = 1'b0;
    ready = 1'b1;
    check({name, "_done_pulses"}, done_cnt - d0, 1);
    check({name, "_cycles"}, cycles, n + stalls + 2);
    check({name, "_busy_cycles"}, busy_cnt - b0, n + stalls + 1);
    check({name, "_valid_cycles"}, valid_cnt - v0, n + stalls);
    check({name, "_queue_left"}, q.size(), 0);
    check({name, "_busy_after"}, longint'(busy), 0);
    $display("seq %s: N=%0d stalls=%0d cycles=%0d", name, n, stalls, cycles);
  endtask

  task automatic check_zero(input string name);
    check({name, "_valid"}, longint'(valid), 0);
    check({name, "_busy"},  longint'(busy), 0);
    check({name, "_done"},  longint'(done), 0);
    check({name, "_last"},  longint'(last), 0);
    check({name, "_idx"},   longint'(idx), 0);
    check({name, "_theta"}, longint'(theta), 0);
  endtask

  initial begin
    int guard;
    rst = 1'b1; start = 1'b0; ready = 1'b1;
    seed = '0; delta = '0; count = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    run_seq("quad", 0.0, 90.0, 4, 0, -1, 0, 1'b0, 1'b0);
    run_seq("stall", 0.0, 90.0, 4, 0, 1, 3, 1'b0, 1'b0);
    run_seq("zero_n", 0.0, 90.0, 0, 0, -1, 0, 1'b0, 1'b0);
    run_seq("poke", 0.0, 90.0, 8, 0, -1, 0, 1'b0, 1'b1);
    run_seq("single", 45.0, 10.0, 1, 0, -1, 0, 1'b0, 1'b0);

    // Reset in the middle of a sequence, then restart on the first free cycle.
    begin
      int d0;
      push_exp(0.0, 90.0, 4, 0);
      d0 = done_cnt;
      drive_start(0.0, 90.0, 4);
      guard = 0;
      do begin
        @(posedge clk); #1;
        start = 1'b0;
        guard++;
      end while (!(valid && idx == CW'(2)) && guard < 20);
      check("rst_reach_idx2", guard < 20, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_zero("midrst");
      check("midrst_no_done", done_cnt - d0, 0);
      q.delete();
      $display("seq midrst: reset applied at idx 2");
    end
    run_seq("after_rst", 0.0, 90.0, 4, 0, -1, 0, 1'b0, 1'b0);

    run_seq("deg1_360", 0.0, 1.0, 360, 2048, -1, 0, 1'b0, 1'b0);
    run_seq("deg1_361", 0.0, 1.0, 361, 2048, -1, 0, 1'b0, 1'b0);
    run_seq("rand_rdy", 30.0, 7.0, 25, 256, -1, 0, 1'b1, 1'b0);
    run_seq("max_n", 0.0, 0.0, 511, 0, -1, 0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
